// File: rtl/tmp2_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tmp2_mon_pkg                                               |
// | Brief   : Shared types, display encodings and sizing helper for the  |
// |           multi-channel TMP2 poll/statistics engine.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package tmp2_mon_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_STORE = 3'd3,
      S_NEXT  = 3'd4
   } state_t;

   // disp_field selections
   localparam logic [1:0] FIELD_LATEST = 2'd0;
   localparam logic [1:0] FIELD_MIN    = 2'd1;
   localparam logic [1:0] FIELD_MAX    = 2'd2;
   localparam logic [1:0] FIELD_FLAGS  = 2'd3;

   // bit positions inside the flags word shown on the display
   localparam int FLAG_HAVE_BIT  = 0;
   localparam int FLAG_TMO_BIT   = 1;
   localparam int FLAG_ALARM_BIT = 2;

   // ceil(log2(n)) but never below one bit, so single-entry selectors still exist
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmp2_mon_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tmp2_mon_if                                                |
// | Brief   : Bundle of request/busy/valid/reading signals between the   |
// |           poll engine (master) and the TMP2 channel instances.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface tmp2_mon_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic [NUM_CH-1:0]        upd_req;
   logic [NUM_CH-1:0]        ch_busy;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] ch_temp;

   modport master (output upd_req, input ch_busy, input ch_valid, input ch_temp);
   modport slave  (input upd_req, output ch_busy, output ch_valid, output ch_temp);
endinterface
`default_nettype wire

// File: rtl/tmp2_ch_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tmp2_ch_stats                                              |
// | Brief   : Per-channel statistics: latest/min/max reading, have flag, |
// |           hysteretic over-temperature alarm, sticky timeout flag.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tmp2_ch_stats #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_en,
   input  logic              timeout_set,
   input  logic              clear,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] alarm_high,
   input  logic [DATA_W-1:0] alarm_hyst,
   output logic [DATA_W-1:0] latest,
   output logic [DATA_W-1:0] min_val,
   output logic [DATA_W-1:0] max_val,
   output logic              have,
   output logic              alarm,
   output logic              timeout_err
);
   // Two extra bits keep the lower bound exact even for the most negative
   // threshold combined with the largest hysteresis.
   logic signed [DATA_W+1:0] sample_x;
   logic signed [DATA_W+1:0] high_x;
   logic signed [DATA_W+1:0] low_x;

   assign sample_x = {{2{sample[DATA_W-1]}}, sample};
   assign high_x   = {{2{alarm_high[DATA_W-1]}}, alarm_high};
   assign low_x    = high_x - $signed({2'b00, alarm_hyst});

   // Clear is applied before a same-cycle store, so the store reseeds min/max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latest      <= '0;
         min_val     <= '0;
         max_val     <= '0;
         have        <= 1'b0;
         alarm       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (clear) begin
            min_val     <= '0;
            max_val     <= '0;
            have        <= 1'b0;
            timeout_err <= 1'b0;
         end
         if (timeout_set) begin
            timeout_err <= 1'b1;
         end
         if (store_en) begin
            latest <= sample;
            if (clear || !have) begin
               min_val <= sample;
               max_val <= sample;
               have    <= 1'b1;
            end else begin
               if ($signed(sample) < $signed(min_val)) min_val <= sample;
               if ($signed(sample) > $signed(max_val)) max_val <= sample;
            end
            if (sample_x > high_x) begin
               alarm <= 1'b1;
            end else if (sample_x < low_x) begin
               alarm <= 1'b0;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/tmp2_multi_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tmp2_multi_monitor                                         |
// | Brief   : Round-robin poll engine for NUM_CH TMP2 channels with      |
// |           per-channel statistics and a registered display mux.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tmp2_multi_monitor
   import tmp2_mon_pkg::*;
#(
   parameter int  NUM_CH   = 4,
   parameter int  DATA_W   = 16,
   parameter int  POLL_CYC = 100000000,
   parameter int  TMO_CYC  = 1000000,
   localparam int SEL_W    = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clear_stats,
   input  logic [DATA_W-1:0] alarm_high,
   input  logic [DATA_W-1:0] alarm_hyst,
   tmp2_mon_if.master        mon_bus,
   input  logic [SEL_W-1:0]  disp_sel,
   input  logic [1:0]        disp_field,
   output logic [DATA_W-1:0] disp_value,
   output logic [NUM_CH-1:0] alarm,
   output logic [NUM_CH-1:0] timeout_err,
   output logic              sweep_done
);
   localparam int CNT_W = clog2_min1(POLL_CYC);
   localparam int TMR_W = clog2_min1(TMO_CYC);

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ch, ch_nxt;
   logic [CNT_W-1:0]   period_cnt;
   logic [TMR_W-1:0]   tmr;
   logic               tick;
   logic               tmr_expired;
   logic               tmr_clr;
   logic               store_en;
   logic               timeout_set;
   logic               last_ch;
   logic [NUM_CH-1:0]  req_vec;

   logic [DATA_W-1:0]  ch_latest [NUM_CH];
   logic [DATA_W-1:0]  ch_min    [NUM_CH];
   logic [DATA_W-1:0]  ch_max    [NUM_CH];
   logic [NUM_CH-1:0]  ch_have;

   assign tick        = enable && (period_cnt == CNT_W'(POLL_CYC - 1));
   assign tmr_expired = (tmr >= TMR_W'(TMO_CYC - 1));
   assign last_ch     = (int'(ch) == NUM_CH - 1);
   assign mon_bus.upd_req = req_vec;

   // Sweep period counter: advances only while polling is enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         period_cnt <= '0;
      else if (enable) period_cnt <= tick ? '0 : period_cnt + 1'b1;
   end

   // Per-channel timeout timer: restarted on REQ entry, saturates once expired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                  tmr <= '0;
      else if (tmr_clr)                                         tmr <= '0;
      else if ((state == S_REQ || state == S_WAIT) && !tmr_expired) tmr <= tmr + 1'b1;
   end

   // FSM state and channel index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ch    <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // Next-state and strobe decode; ticks outside IDLE are simply not looked at.
   always_comb begin
      state_nxt   = state;
      ch_nxt      = ch;
      req_vec     = '0;
      sweep_done  = 1'b0;
      store_en    = 1'b0;
      timeout_set = 1'b0;
      tmr_clr     = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) begin
               state_nxt = S_REQ;
               tmr_clr   = 1'b1;
            end
         end
         S_REQ: begin
            if (!mon_bus.ch_busy[ch]) begin
               req_vec[ch] = 1'b1;
               state_nxt   = S_WAIT;
            end else if (tmr_expired) begin
               timeout_set = 1'b1;
               state_nxt   = S_NEXT;
            end
         end
         S_WAIT: begin
            if (mon_bus.ch_valid[ch]) begin
               state_nxt = S_STORE;
            end else if (tmr_expired) begin
               timeout_set = 1'b1;
               state_nxt   = S_NEXT;
            end
         end
         S_STORE: begin
            store_en  = 1'b1;
            state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (last_ch || !enable) begin
               ch_nxt     = '0;
               sweep_done = last_ch;
               state_nxt  = S_IDLE;
            end else begin
               ch_nxt    = ch + 1'b1;
               state_nxt = S_REQ;
               tmr_clr   = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      tmp2_ch_stats #(.DATA_W(DATA_W)) u_stats (
         .clk         (clk),
         .rst         (rst),
         .store_en    (store_en && (ch == SEL_W'(k))),
         .timeout_set (timeout_set && (ch == SEL_W'(k))),
         .clear       (clear_stats),
         .sample      (mon_bus.ch_temp[k*DATA_W +: DATA_W]),
         .alarm_high  (alarm_high),
         .alarm_hyst  (alarm_hyst),
         .latest      (ch_latest[k]),
         .min_val     (ch_min[k]),
         .max_val     (ch_max[k]),
         .have        (ch_have[k]),
         .alarm       (alarm[k]),
         .timeout_err (timeout_err[k])
      );
   end

   // Registered display mux; out-of-range channel selects read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_value <= '0;
      end else if (int'(disp_sel) >= NUM_CH) begin
         disp_value <= '0;
      end else begin
         case (disp_field)
            FIELD_LATEST: disp_value <= ch_latest[disp_sel];
            FIELD_MIN:    disp_value <= ch_min[disp_sel];
            FIELD_MAX:    disp_value <= ch_max[disp_sel];
            default: begin
               disp_value                 <= '0;
               disp_value[FLAG_ALARM_BIT] <= alarm[disp_sel];
               disp_value[FLAG_TMO_BIT]   <= timeout_err[disp_sel];
               disp_value[FLAG_HAVE_BIT]  <= ch_have[disp_sel];
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tmp2_multi_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_tmp2_multi_monitor                                      |
// | Brief   : Directed self-checking bench for tmp2_multi_monitor with   |
// |           behavioural TMP2 channel responders.                       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_tmp2_multi_monitor;
   import tmp2_mon_pkg::*;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 16;
   localparam int POLL_CYC = 50;
   localparam int TMO_CYC  = 20;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic        enable      = 1'b0;
   logic        clear_stats = 1'b0;
   logic [15:0] alarm_high  = 16'h7FFF;
   logic [15:0] alarm_hyst  = 16'h0000;
   logic [1:0]  disp_sel    = 2'd0;
   logic [1:0]  disp_field  = 2'd0;
   logic [15:0] disp_value;
   logic [3:0]  alarm;
   logic [3:0]  timeout_err;
   logic        sweep_done;

   // responder controls (written by the main sequence only)
   logic [15:0] val [4] = '{16'h0C80, 16'h0D00, 16'hF380, 16'h0000};
   logic [3:0]  resp_en     = 4'b1111;
   logic [3:0]  force_valid = 4'b0000;

   // responder observations (written by the responder only)
   int cyc;
   int done_count;
   int req_count [4];
   int req_cyc   [4];
   int to_cyc    [4];
   int req_log   [$];

   int checks = 0;
   int errors = 0;

   tmp2_mon_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) mon_bus ();

   tmp2_multi_monitor #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .POLL_CYC(POLL_CYC), .TMO_CYC(TMO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear_stats(clear_stats),
      .alarm_high(alarm_high), .alarm_hyst(alarm_hyst), .mon_bus(mon_bus),
      .disp_sel(disp_sel), .disp_field(disp_field), .disp_value(disp_value),
      .alarm(alarm), .timeout_err(timeout_err), .sweep_done(sweep_done)
   );

   initial forever #5 clk = ~clk;

   // Channel model: valid pulses 3 cycles after a request, plus injected strays.
   initial begin
      logic [3:0] v;
      int cnt [4];
      logic [3:0] prev_to;
      cyc = 0;
      done_count = 0;
      prev_to = '0;
      for (int k = 0; k < 4; k++) begin
         cnt[k] = 0; req_count[k] = 0; req_cyc[k] = 0; to_cyc[k] = 0;
      end
      mon_bus.ch_valid = '0;
      mon_bus.ch_temp  = '0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         v = force_valid;
         for (int k = 0; k < 4; k++) begin
            if (cnt[k] > 0) begin
               cnt[k]--;
               if (cnt[k] == 0) v[k] = 1'b1;
            end
            if (mon_bus.upd_req[k]) begin
               req_count[k]++;
               req_cyc[k] = cyc;
               req_log.push_back(k);
               if (resp_en[k]) cnt[k] = 3;
            end
            if (timeout_err[k] && !prev_to[k]) to_cyc[k] = cyc;
            mon_bus.ch_temp[k*16 +: 16] = val[k];
         end
         prev_to = timeout_err;
         if (sweep_done) done_count++;
         mon_bus.ch_valid = v;
      end
   end

   task automatic do_sweep(output bit ok);
      int base;
      base = done_count;
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #2;
         if (done_count > base) begin ok = 1'b1; break; end
      end
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic wait_req(input int k, input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #2;
         if (req_count[k] > base) begin ok = 1'b1; break; end
      end
   endtask

   task automatic read_disp(input logic [1:0] s, input logic [1:0] f, output logic [15:0] v);
      @(negedge clk);
      disp_sel = s;
      disp_field = f;
      @(negedge clk); #2;
      v = disp_value;
   endtask

   task automatic pulse_clear;
      @(negedge clk); clear_stats = 1'b1;
      @(negedge clk); clear_stats = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      repeat (3) @(negedge clk);
      #2;
      checks++; if (mon_bus.upd_req !== 4'b0) begin errors++; $display("FAIL reset_upd_req: got %b expected 0000", mon_bus.upd_req); end
      checks++; if (alarm !== 4'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0000", alarm); end
      checks++; if (timeout_err !== 4'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0000", timeout_err); end
      checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
      rst = 1'b0;
      read_disp(2'd0, FIELD_LATEST, v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_latest0: got %h expected 0000", v); end
      read_disp(2'd2, FIELD_FLAGS, v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_flags2: got %h expected 0000", v); end
   endtask

   task automatic test_sweep;
      bit ok;
      int bl, bd;
      logic [7:0] ord;
      logic [15:0] v;
      logic [15:0] exp_l [4] = '{16'h0C80, 16'h0D00, 16'hF380, 16'h0000};
      bl = req_log.size();
      bd = done_count;
      do_sweep(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sweep_wait: got no sweep_done expected one"); end
      repeat (10) @(negedge clk);
      checks++; if (done_count - bd !== 1) begin errors++; $display("FAIL sweep_done_count: got %0d expected 1", done_count - bd); end
      checks++; if (req_log.size() - bl !== 4) begin errors++; $display("FAIL sweep_req_count: got %0d expected 4", req_log.size() - bl); end
      ord = 8'hFF;
      if (req_log.size() >= bl + 4)
         for (int i = 0; i < 4; i++) ord[7-2*i -: 2] = 2'(req_log[bl+i]);
      checks++; if (ord !== 8'b00_01_10_11) begin errors++; $display("FAIL sweep_order: got %b expected 00011011", ord); end
      for (int k = 0; k < 4; k++) begin
         read_disp(2'(k), FIELD_LATEST, v);
         checks++; if (v !== exp_l[k]) begin errors++; $display("FAIL sweep_latest%0d: got %h expected %h", k, v, exp_l[k]); end
      end
      read_disp(2'd2, FIELD_MIN, v);
      checks++; if (v !== 16'hF380) begin errors++; $display("FAIL sweep_min2: got %h expected f380", v); end
      read_disp(2'd2, FIELD_MAX, v);
      checks++; if (v !== 16'hF380) begin errors++; $display("FAIL sweep_max2: got %h expected f380", v); end
      read_disp(2'd0, FIELD_FLAGS, v);
      checks++; if (v !== 16'h0001) begin errors++; $display("FAIL sweep_flags0: got %h expected 0001", v); end
   endtask

   task automatic test_minmax;
      bit ok;
      int b0;
      logic [15:0] v;
      val[0] = 16'hF000;
      do_sweep(ok);
      val[0] = 16'h1000;
      do_sweep(ok);
      read_disp(2'd0, FIELD_LATEST, v);
      checks++; if (v !== 16'h1000) begin errors++; $display("FAIL minmax_latest: got %h expected 1000", v); end
      read_disp(2'd0, FIELD_MIN, v);
      checks++; if (v !== 16'hF000) begin errors++; $display("FAIL minmax_min: got %h expected f000", v); end
      read_disp(2'd0, FIELD_MAX, v);
      checks++; if (v !== 16'h1000) begin errors++; $display("FAIL minmax_max: got %h expected 1000", v); end
      // clear_stats lands in ch0's STORE cycle (4 cycles after its request)
      val[0] = 16'h0500;
      b0 = req_count[0];
      enable = 1'b1;
      wait_req(0, b0, ok);
      repeat (4) @(negedge clk);
      clear_stats = 1'b1;
      @(negedge clk);
      clear_stats = 1'b0;
      do_sweep(ok);
      checks++; if (!ok) begin errors++; $display("FAIL minmax_clear_wait: got no sweep_done expected one"); end
      read_disp(2'd0, FIELD_MIN, v);
      checks++; if (v !== 16'h0500) begin errors++; $display("FAIL minmax_clear_min: got %h expected 0500", v); end
      read_disp(2'd0, FIELD_MAX, v);
      checks++; if (v !== 16'h0500) begin errors++; $display("FAIL minmax_clear_max: got %h expected 0500", v); end
   endtask

   task automatic test_hysteresis;
      bit ok;
      logic [15:0] smp [5] = '{16'h1000, 16'h1001, 16'h0F80, 16'h0F00, 16'h0EFF};
      logic        exp [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      alarm_high = 16'h1000;
      alarm_hyst = 16'h0100;
      for (int i = 0; i < 5; i++) begin
         val[1] = smp[i];
         do_sweep(ok);
         checks++;
         if (alarm !== {2'b00, exp[i], 1'b0}) begin
            errors++;
            $display("FAIL hyst_step%0d: got %b expected %b", i, alarm, {2'b00, exp[i], 1'b0});
         end
      end
      alarm_high = 16'h7FFF;
      alarm_hyst = 16'h0000;
   endtask

   task automatic test_timeout;
      bit ok;
      int b2, b3;
      logic [15:0] v;
      resp_en = 4'b1011;
      b3 = req_count[3];
      do_sweep(ok);
      checks++; if (timeout_err !== 4'b0100) begin errors++; $display("FAIL tmo_flag: got %b expected 0100", timeout_err); end
      checks++; if (to_cyc[2] - req_cyc[2] !== 20) begin errors++; $display("FAIL tmo_latency: got %0d expected 20", to_cyc[2] - req_cyc[2]); end
      checks++; if (req_count[3] - b3 !== 1) begin errors++; $display("FAIL tmo_ch3_polled: got %0d expected 1", req_count[3] - b3); end
      read_disp(2'd2, FIELD_LATEST, v);
      checks++; if (v !== 16'hF380) begin errors++; $display("FAIL tmo_latest2: got %h expected f380", v); end
      pulse_clear();
      @(negedge clk); #2;
      checks++; if (timeout_err !== 4'b0000) begin errors++; $display("FAIL tmo_clear: got %b expected 0000", timeout_err); end
      // busy stuck high: no request issued, still times out
      resp_en = 4'b1111;
      mon_bus.ch_busy = 4'b0100;
      b2 = req_count[2];
      b3 = req_count[3];
      do_sweep(ok);
      checks++; if (timeout_err !== 4'b0100) begin errors++; $display("FAIL busy_tmo_flag: got %b expected 0100", timeout_err); end
      checks++; if (req_count[2] - b2 !== 0) begin errors++; $display("FAIL busy_no_req2: got %0d expected 0", req_count[2] - b2); end
      checks++; if (req_count[3] - b3 !== 1) begin errors++; $display("FAIL busy_ch3_polled: got %0d expected 1", req_count[3] - b3); end
      mon_bus.ch_busy = 4'b0000;
      pulse_clear();
   endtask

   task automatic test_stray_late;
      bit ok;
      int b1, b2, bd, bl, a0;
      logic [15:0] v;
      // stray valid on ch3 while ch1 waits must not end ch1's wait early
      b1 = req_count[1];
      bd = done_count;
      enable = 1'b1;
      wait_req(1, b1, ok);
      @(negedge clk); force_valid = 4'b1000;
      @(negedge clk); force_valid = 4'b0000;
      for (int i = 0; i < 100 && done_count == bd; i++) begin @(negedge clk); #2; end
      @(negedge clk); enable = 1'b0;
      checks++; if (req_cyc[2] - req_cyc[1] !== 6) begin errors++; $display("FAIL stray_ch1_span: got %0d expected 6", req_cyc[2] - req_cyc[1]); end
      // two timing-out channels stretch the sweep past the next tick
      resp_en = 4'b1001;
      bd = done_count;
      enable = 1'b1;
      for (int i = 0; i < 300 && done_count == bd; i++) begin @(negedge clk); #2; end
      a0 = req_cyc[0];
      for (int i = 0; i < 300 && done_count == bd + 1; i++) begin @(negedge clk); #2; end
      @(negedge clk); enable = 1'b0;
      checks++; if (req_cyc[0] - a0 !== 100) begin errors++; $display("FAIL tick_dropped: got %0d expected 100", req_cyc[0] - a0); end
      resp_en = 4'b1111;
      pulse_clear();
      // enable dropped during ch1 WAIT
      val[1] = 16'h0ABC;
      b1 = req_count[1];
      b2 = req_count[2];
      bd = done_count;
      enable = 1'b1;
      wait_req(1, b1, ok);
      @(negedge clk); enable = 1'b0;
      repeat (60) @(negedge clk);
      checks++; if (req_count[2] - b2 !== 0) begin errors++; $display("FAIL late_no_req2: got %0d expected 0", req_count[2] - b2); end
      checks++; if (done_count - bd !== 0) begin errors++; $display("FAIL late_no_done: got %0d expected 0", done_count - bd); end
      read_disp(2'd1, FIELD_LATEST, v);
      checks++; if (v !== 16'h0ABC) begin errors++; $display("FAIL late_latest1: got %h expected 0abc", v); end
      bl = req_log.size();
      do_sweep(ok);
      checks++;
      if (req_log.size() <= bl || req_log[bl] !== 0) begin
         errors++;
         $display("FAIL late_restart_ch0: got %0d entries expected first request on ch0", req_log.size() - bl);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int b1, bl;
      logic [15:0] v;
      alarm_high = 16'h0100;
      val[0] = 16'h0500;
      @(negedge clk);
      disp_sel = 2'd0;
      disp_field = FIELD_LATEST;
      b1 = req_count[1];
      enable = 1'b1;
      wait_req(1, b1, ok);
      checks++; if (mon_bus.upd_req !== 4'b0010) begin errors++; $display("FAIL rstmid_pre_req: got %b expected 0010", mon_bus.upd_req); end
      checks++; if (alarm !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_alarm: got %b expected 0001", alarm); end
      checks++; if (disp_value !== 16'h0500) begin errors++; $display("FAIL rstmid_pre_disp: got %h expected 0500", disp_value); end
      rst = 1'b1;
      #1;
      checks++; if (mon_bus.upd_req !== 4'b0000) begin errors++; $display("FAIL rstmid_upd_req: got %b expected 0000", mon_bus.upd_req); end
      checks++; if (alarm !== 4'b0000) begin errors++; $display("FAIL rstmid_alarm: got %b expected 0000", alarm); end
      checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL rstmid_disp: got %h expected 0000", disp_value); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b1 = req_count[1];
      bl = req_log.size();
      repeat (10) @(negedge clk);
      checks++; if (req_count[1] - b1 !== 0) begin errors++; $display("FAIL rstmid_idle: got %0d expected 0", req_count[1] - b1); end
      read_disp(2'd0, FIELD_FLAGS, v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rstmid_flags0: got %h expected 0000", v); end
      for (int i = 0; i < 100 && req_log.size() == bl; i++) begin @(negedge clk); #2; end
      checks++;
      if (req_log.size() <= bl || req_log[bl] !== 0) begin
         errors++;
         $display("FAIL rstmid_restart_ch0: got %0d entries expected first request on ch0", req_log.size() - bl);
      end
      @(negedge clk); enable = 1'b0;
      alarm_high = 16'h7FFF;
   endtask

   initial begin
      mon_bus.ch_busy = 4'b0000;
      test_reset();
      test_sweep();
      test_minmax();
      test_hysteresis();
      test_timeout();
      test_stray_late();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
